// File: rtl/mash_sequencer.sv
// Start-up and FCW-update sequencer for a cascaded MASH modulator.
// Walks IDLE -> CLEAR -> SETTLE -> RUN and applies buffered FCW updates on frame boundaries.
module mash_sequencer #(
  parameter int WIDTH         = 16,
  parameter int SETTLE_CYCLES = 8,
  parameter int FRAME_LEN     = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             run_en,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [WIDTH-1:0] cfg_fcw,
  input  logic             cfg_clear,
  output logic [WIDTH-1:0] stage_in,
  output logic             stage_en,
  output logic             stage_clr,
  output logic             out_valid,
  output logic             frame_tick,
  output logic             busy
);

  localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam int FW = $clog2(FRAME_LEN);
  localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYCLES - 1);
  localparam logic [FW-1:0] FRAME_LAST  = FW'(FRAME_LEN - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CLEAR,
    S_SETTLE,
    S_RUN
  } state_t;

  state_t           state, state_nx;
  logic [SW-1:0]    scnt, scnt_nx;
  logic [FW-1:0]    fcnt, fcnt_nx;
  logic             pending, pending_nx;
  logic [WIDTH-1:0] sh_fcw;
  logic             sh_clr;
  logic [WIDTH-1:0] stage_in_nx;
  logic             accept;
  logic             at_frame_end;

  assign cfg_ready    = ((state == S_IDLE) || (state == S_RUN)) && !pending;
  assign accept       = cfg_valid && cfg_ready;
  assign at_frame_end = (fcnt == FRAME_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      scnt    <= '0;
      fcnt    <= '0;
      pending <= 1'b0;
    end else begin
      state   <= state_nx;
      scnt    <= scnt_nx;
      fcnt    <= fcnt_nx;
      pending <= pending_nx;
    end
  end

  // Shadow only loads on accept, and accept requires !pending, so it never
  // overwrites an update that is still waiting for its frame boundary.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh_fcw <= '0;
      sh_clr <= 1'b0;
    end else if (accept) begin
      sh_fcw <= cfg_fcw;
      sh_clr <= cfg_clear;
    end
  end

  always_comb begin
    state_nx    = state;
    scnt_nx     = scnt;
    fcnt_nx     = fcnt;
    pending_nx  = pending;
    stage_in_nx = stage_in;
    if (accept) pending_nx = 1'b1;
    case (state)
      S_IDLE: begin
        if (pending) begin
          stage_in_nx = sh_fcw;
          pending_nx  = 1'b0;
        end
        if (run_en) state_nx = S_CLEAR;
      end
      S_CLEAR: begin
        scnt_nx  = SETTLE_LAST;
        state_nx = run_en ? S_SETTLE : S_IDLE;
      end
      S_SETTLE: begin
        if (!run_en) begin
          state_nx = S_IDLE;
        end else if (scnt == '0) begin
          state_nx = S_RUN;
          fcnt_nx  = '0;
        end else begin
          scnt_nx = scnt - SW'(1);
        end
      end
      S_RUN: begin
        if (!run_en) begin
          state_nx = S_IDLE;
        end else begin
          fcnt_nx = at_frame_end ? '0 : fcnt + FW'(1);
          if (at_frame_end && pending) begin
            stage_in_nx = sh_fcw;
            pending_nx  = 1'b0;
            if (sh_clr) state_nx = S_CLEAR;
          end
        end
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // Outputs are registered decodes of the next state so they line up with the state they describe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stage_in   <= '0;
      stage_en   <= 1'b0;
      stage_clr  <= 1'b0;
      out_valid  <= 1'b0;
      frame_tick <= 1'b0;
      busy       <= 1'b0;
    end else begin
      stage_in   <= stage_in_nx;
      stage_en   <= (state_nx == S_SETTLE) || (state_nx == S_RUN);
      stage_clr  <= (state_nx == S_CLEAR);
      out_valid  <= (state_nx == S_RUN);
      frame_tick <= (state_nx == S_RUN) && (fcnt_nx == FRAME_LAST);
      busy       <= (state_nx == S_CLEAR) || (state_nx == S_SETTLE);
    end
  end

endmodule

// File: tb/tb_mash_sequencer.sv
// Directed bench for mash_sequencer: phase/age reference model checked every cycle,
// plus hand-computed expectations for the start-up, update, clear and reset scenarios.
module tb_mash_sequencer;

  localparam int W  = 16;
  localparam int S  = 4;
  localparam int FL = 8;

  logic         clk, rst_n, run_en, cfg_valid, cfg_clear;
  logic [W-1:0] cfg_fcw;
  logic         cfg_ready, stage_en, stage_clr, out_valid, frame_tick, busy;
  logic [W-1:0] stage_in;

  int checks   = 0;
  int failures = 0;

  mash_sequencer #(.WIDTH(W), .SETTLE_CYCLES(S), .FRAME_LEN(FL)) dut (
    .clk(clk), .rst_n(rst_n), .run_en(run_en),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_fcw(cfg_fcw), .cfg_clear(cfg_clear),
    .stage_in(stage_in), .stage_en(stage_en), .stage_clr(stage_clr),
    .out_valid(out_valid), .frame_tick(frame_tick), .busy(busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: phase 0=idle 1=clear 2=settle 3=run, age = cycles spent in the phase.
  int           m_phase, m_age, nph;
  logic [W-1:0] m_in, m_sh;
  logic         m_pend, m_shclr, e_tick, e_ready, acc;

  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        m_phase = 0; m_age = 0; m_in = '0; m_sh = '0; m_pend = 1'b0; m_shclr = 1'b0;
      end
      e_tick  = (m_phase == 3) && ((m_age % FL) == FL - 1);
      e_ready = ((m_phase == 0) || (m_phase == 3)) && !m_pend;
      chk("m_stage_in",   32'(stage_in),   32'(m_in));
      chk("m_stage_en",   32'(stage_en),   32'((m_phase == 2) || (m_phase == 3)));
      chk("m_stage_clr",  32'(stage_clr),  32'(m_phase == 1));
      chk("m_out_valid",  32'(out_valid),  32'(m_phase == 3));
      chk("m_busy",       32'(busy),       32'((m_phase == 1) || (m_phase == 2)));
      chk("m_frame_tick", 32'(frame_tick), 32'(e_tick));
      chk("m_cfg_ready",  32'(cfg_ready),  32'(e_ready));
      if (rst_n) begin
        acc = cfg_valid && e_ready;
        nph = m_phase;
        case (m_phase)
          0: begin
            if (m_pend) begin m_in = m_sh; m_pend = 1'b0; end
            if (run_en) nph = 1;
          end
          1: nph = run_en ? 2 : 0;
          2: if (!run_en) nph = 0; else if (m_age == S - 1) nph = 3;
          default: begin
            if (!run_en) nph = 0;
            else if (e_tick && m_pend) begin
              m_in = m_sh; m_pend = 1'b0;
              if (m_shclr) nph = 1;
            end
          end
        endcase
        if (acc) begin m_pend = 1'b1; m_sh = cfg_fcw; m_shclr = cfg_clear; end
        m_age   = (nph == m_phase) ? m_age + 1 : 0;
        m_phase = nph;
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  int n, busy_cnt, clr_cnt, en_nv;

  initial begin
    rst_n = 1'b0; run_en = 1'b0; cfg_valid = 1'b0; cfg_clear = 1'b0; cfg_fcw = '0;
    step(2);
    rst_n = 1'b1;
    step(1);
    chk("rst_ready", 32'(cfg_ready), 1);
    chk("rst_stage_in", 32'(stage_in), 0);

    // IDLE update applies one edge after acceptance
    cfg_valid = 1'b1; cfg_fcw = 16'h1234;
    step(1);
    cfg_valid = 1'b0;
    chk("idle_ready_low", 32'(cfg_ready), 0);
    chk("idle_in_old", 32'(stage_in), 0);
    step(1);
    chk("idle_in_1234", 32'(stage_in), 32'h1234);
    chk("idle_ready_back", 32'(cfg_ready), 1);

    // start-up: 1 clear cycle, S settle cycles, then run
    run_en = 1'b1;
    busy_cnt = 0; clr_cnt = 0; en_nv = 0;
    for (int i = 0; i < 10; i++) begin
      step(1);
      busy_cnt += int'(busy);
      clr_cnt  += int'(stage_clr);
      en_nv    += int'(stage_en && !out_valid);
    end
    chk("start_busy_cycles", busy_cnt, 5);
    chk("start_clr_cycles", clr_cnt, 1);
    chk("start_settle_cycles", en_nv, 4);
    chk("start_valid", 32'(out_valid), 1);

    // update accepted mid-frame applies at the edge ending the next frame_tick cycle
    n = 0;
    while (!frame_tick && n < 20) begin step(1); n++; end
    chk("found_tick", 32'(frame_tick), 1);
    step(3);
    cfg_valid = 1'b1; cfg_fcw = 16'h4000; cfg_clear = 1'b0;
    step(1);
    cfg_fcw = 16'h5555;
    chk("run_held_off", 32'(cfg_ready), 0);
    n = 0;
    while (stage_in != 16'h4000 && n < 20) begin step(1); n++; end
    chk("run_in_4000", 32'(stage_in), 32'h4000);
    chk("run_apply_wait", n, 5);
    chk("run_valid_kept", 32'(out_valid), 1);
    chk("run_ready_after_apply", 32'(cfg_ready), 1);
    step(1);
    cfg_valid = 1'b0;
    chk("run_second_pending", 32'(cfg_ready), 0);
    chk("run_in_still_4000", 32'(stage_in), 32'h4000);
    n = 0;
    while (stage_in != 16'h5555 && n < 20) begin step(1); n++; end
    chk("run_in_5555", 32'(stage_in), 32'h5555);

    // clearing update: new FCW with a clear cycle, then full settle
    cfg_valid = 1'b1; cfg_fcw = 16'h8000; cfg_clear = 1'b1;
    step(1);
    cfg_valid = 1'b0; cfg_clear = 1'b0;
    n = 0;
    while (stage_in != 16'h8000 && n < 20) begin step(1); n++; end
    chk("clr_in_8000", 32'(stage_in), 32'h8000);
    chk("clr_pulse", 32'(stage_clr), 1);
    chk("clr_valid_low", 32'(out_valid), 0);
    n = 0;
    while (!out_valid && n < 20) begin step(1); n++; end
    chk("clr_resettle", n, 5);

    // run_en drop from RUN, then from SETTLE
    run_en = 1'b0;
    step(1);
    chk("drop_run_en", 32'(stage_en), 0);
    chk("drop_run_valid", 32'(out_valid), 0);
    run_en = 1'b1;
    step(3);
    chk("in_settle", 32'(busy), 1);
    run_en = 1'b0;
    step(1);
    chk("drop_settle_en", 32'(stage_en), 0);
    chk("drop_settle_busy", 32'(busy), 0);

    // pending update survives a drop from RUN and applies in IDLE
    run_en = 1'b1;
    n = 0;
    while (!out_valid && n < 20) begin step(1); n++; end
    cfg_valid = 1'b1; cfg_fcw = 16'h00FF;
    step(1);
    cfg_valid = 1'b0; run_en = 1'b0;
    step(1);
    chk("pend_idle_en", 32'(stage_en), 0);
    chk("pend_idle_in_old", 32'(stage_in), 32'h8000);
    step(1);
    chk("pend_idle_in_00ff", 32'(stage_in), 32'h00FF);

    // FCW extremes pass through untouched
    cfg_valid = 1'b1; cfg_fcw = 16'h0000;
    step(1); cfg_valid = 1'b0; step(1);
    chk("fcw_zero", 32'(stage_in), 0);
    cfg_valid = 1'b1; cfg_fcw = 16'hFFFF;
    step(1); cfg_valid = 1'b0; step(1);
    chk("fcw_ones", 32'(stage_in), 32'hFFFF);

    // reset mid-SETTLE with an update pending
    run_en = 1'b1; cfg_valid = 1'b1; cfg_fcw = 16'hABCD;
    step(1);
    cfg_valid = 1'b0;
    step(2);
    chk("pre_rst_settle", 32'(busy), 1);
    rst_n = 1'b0;
    #1;
    chk("arst_stage_in", 32'(stage_in), 0);
    chk("arst_en", 32'(stage_en), 0);
    chk("arst_busy", 32'(busy), 0);
    chk("arst_ready", 32'(cfg_ready), 1);
    run_en = 1'b0;
    step(2);
    rst_n = 1'b1;
    step(2);
    chk("post_rst_in", 32'(stage_in), 0);
    chk("post_rst_ready", 32'(cfg_ready), 1);
    run_en = 1'b1;
    step(20);
    chk("post_rst_no_pending", 32'(stage_in), 0);
    chk("post_rst_running", 32'(out_valid), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mash_sequencer.md
Name: mash_sequencer

Overview:
Control block for a cascaded MASH modulator built from first-order accumulator stages. It accepts frequency-control-word (FCW) updates over a valid/ready handshake and drives the stage-1 input, enable and synchronous clear. It sequences start-up through clear and settle phases, and applies FCW updates only on frame boundaries. It sits between the configuration/register interface and the MASH stage chain.

Parameters:
WIDTH, 16, width of the FCW and of stage_in
SETTLE_CYCLES, 8, number of enabled cycles after a clear before out_valid asserts (must be >= 1)
FRAME_LEN, 16, number of RUN cycles per frame; FCW updates apply at frame boundaries (must be >= 2)

Ports:
clk  input  1  clock
rst_n  input  1  asynchronous active-low reset
run_en  input  1  level; 1 requests modulator operation
cfg_valid  input  1  FCW update offered
cfg_ready  output  1  sequencer can accept an update this cycle
cfg_fcw  input  WIDTH  new FCW value
cfg_clear  input  1  sampled with cfg_fcw; 1 forces an accumulator restart when the update applies
stage_in  output  WIDTH  FCW driven to the stage-1 input
stage_en  output  1  clock enable for all MASH stages
stage_clr  output  1  one-cycle synchronous clear to all MASH stages
out_valid  output  1  modulator output is settled and usable
frame_tick  output  1  one-cycle pulse on the last RUN cycle of each frame
busy  output  1  state is CLEAR or SETTLE

Behaviour:
- Reset (asynchronous, rst_n=0): state=IDLE; stage_in=0; stage_en=0; stage_clr=0; out_valid=0; frame_tick=0; busy=0; pending=0; settle and frame counters=0. cfg_ready reads 1 while reset is held.
- All outputs except cfg_ready are registered. cfg_ready = (state==IDLE || state==RUN) && !pending.
- Handshake: an update is accepted on a rising clk edge with cfg_valid && cfg_ready. cfg_fcw and cfg_clear are captured into shadow registers and pending is set. cfg_ready drops in the following cycle. Only one update is held at a time.
- State IDLE: stage_en=0, out_valid=0.
  - If pending: stage_in <= shadow on the next edge and pending clears. No frame wait; cfg_clear is ignored in IDLE.
  - run_en=1 -> CLEAR.
- State CLEAR (exactly 1 cycle): stage_clr=1, stage_en=0, busy=1. Settle counter loads SETTLE_CYCLES-1. Next state is SETTLE; if run_en=0, next state is IDLE.
- State SETTLE: stage_en=1, busy=1, out_valid=0. The counter decrements each cycle.
  - Counter==0 -> RUN, with the frame counter loaded to 0.
  - run_en=0 -> IDLE on the next edge (takes priority).
- State RUN: stage_en=1, out_valid=1. The frame counter increments and wraps at FRAME_LEN-1. frame_tick=1 on cycles where the counter equals FRAME_LEN-1.
  - On a frame_tick cycle with pending: stage_in <= shadow at that edge and pending clears.
  - If the shadow cfg_clear=1, the same edge also moves to CLEAR, which re-runs clear/settle; out_valid drops on the next cycle.
  - run_en=0 -> IDLE on the next edge. Any pending update stays pending and is applied on the first IDLE cycle.
- Priority when events coincide: run_en=0 > frame apply > new accept.
  - An accept in the same cycle as a frame_tick with nothing pending sets pending. That value applies at the next frame_tick, not the current one.
- stage_clr and stage_en are never 1 in the same cycle.
- FCW=0 and FCW=all-ones are legal and passed through unmodified. No arithmetic is performed on the FCW.
- Reset mid-operation: all state is lost immediately, including pending; outputs go to their reset values asynchronously.

Test Plan:
- Reset, then run_en=1 with SETTLE_CYCLES=4 -> stage_clr=1 for 1 cycle, stage_en=1 for 4 cycles with out_valid=0, then out_valid=1; busy high for exactly 5 cycles.
- IDLE, cfg_fcw=0x1234 accepted -> stage_in=0x1234 one cycle later; cfg_ready low for exactly 1 cycle.
- RUN with FRAME_LEN=8, accept 0x4000 (cfg_clear=0) 3 cycles after a frame_tick -> stage_in changes at the edge ending the next frame_tick cycle; out_valid stays 1; a second cfg_valid is held off (cfg_ready=0) until then.
- RUN, accept 0x8000 with cfg_clear=1 -> at frame_tick, stage_in=0x8000, then a CLEAR cycle (stage_clr=1) and SETTLE_CYCLES cycles with out_valid=0, then out_valid=1.
- run_en dropped during SETTLE, then separately during RUN with an update pending -> IDLE next cycle with stage_en=0 and out_valid=0; the pending FCW appears on stage_in one cycle after entering IDLE.
- rst_n asserted mid-SETTLE with an update pending -> all outputs 0 immediately, cfg_ready=1; after release, stage_in stays 0 and the pending update is gone.
